// File: rtl/pn_pkg.sv
// Shared definitions for the Polish-notation evaluator front end: modes,
// operator codes, error codes, feeder FSM states and the buffered token type.
package pn_pkg;

   localparam int unsigned PN_MAX_TOK = 12;
   localparam int unsigned PN_TIMEOUT = 64;

   localparam int unsigned MODE_W = 2;
   localparam int unsigned VAL_W  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned RES_W  = 3;
   localparam int unsigned CODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_PRE_GRP  = 2'd0;
   localparam logic [MODE_W-1:0] MODE_POST_GRP = 2'd1;
   localparam logic [MODE_W-1:0] MODE_PRE      = 2'd2;
   localparam logic [MODE_W-1:0] MODE_POST     = 2'd3;

   localparam logic [VAL_W-1:0] OP_ADD     = 3'd0;
   localparam logic [VAL_W-1:0] OP_SUB     = 3'd1;
   localparam logic [VAL_W-1:0] OP_MUL     = 3'd2;
   localparam logic [VAL_W-1:0] OP_ABS_ADD = 3'd3;

   localparam logic [CODE_W-1:0] ERR_NONE     = 3'd0;
   localparam logic [CODE_W-1:0] ERR_BAD_OP   = 3'd1;
   localparam logic [CODE_W-1:0] ERR_SYNTAX   = 3'd2;
   localparam logic [CODE_W-1:0] ERR_OVERFLOW = 3'd3;
   localparam logic [CODE_W-1:0] ERR_TIMEOUT  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_DRAIN,
      ST_SEND,
      ST_WAIT
   } state_t;

   typedef struct packed {
      logic             op;
      logic [VAL_W-1:0] val;
   } tok_t;

endpackage : pn_pkg

// File: rtl/pn_syntax_check.sv
// Incremental expression syntax checker.
// Ports: clk/rst_n; i_xfer strobes one accepted token (i_operator, i_value)
// under mode i_mode; i_first restarts the counters with that token.
// o_pass_c / o_bad_op_c give the verdict including the current token, so the
// feeder can decide on the same cycle as the s_last handshake.
module pn_syntax_check
   import pn_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_xfer,
   input  logic              i_first,
   input  logic [MODE_W-1:0] i_mode,
   input  logic              i_operator,
   input  logic [VAL_W-1:0]  i_value,
   output logic              o_pass_c,
   output logic              o_bad_op_c
);

   localparam int unsigned LVL_W = 5;

   logic             r_bad_op, r_ok;
   logic [LVL_W-1:0] r_need, r_depth;
   logic [1:0]       r_pos;

   logic             w_bad_base, w_ok_base, w_bad_nxt, w_ok_nxt;
   logic             w_tok_ok, w_final_ok;
   logic [LVL_W-1:0] w_need_base, w_depth_base, w_need_nxt, w_depth_nxt;
   logic [1:0]       w_pos_base, w_pos_nxt;

   // Verdict for the running expression with the current token folded in
   always_comb begin
      w_bad_base   = ~i_first & r_bad_op;
      w_ok_base    = i_first | r_ok;
      w_need_base  = i_first ? LVL_W'(1) : r_need;
      w_depth_base = i_first ? '0 : r_depth;
      w_pos_base   = i_first ? '0 : r_pos;

      w_bad_nxt   = w_bad_base | (i_operator & (i_value > OP_ABS_ADD));
      w_pos_nxt   = (w_pos_base == 2'd2) ? 2'd0 : w_pos_base + 2'd1;
      w_need_nxt  = w_need_base;
      w_depth_nxt = w_depth_base;
      w_tok_ok    = 1'b1;
      w_final_ok  = 1'b0;

      case (i_mode)
         MODE_PRE_GRP: begin
            w_tok_ok   = (i_operator == (w_pos_base == 2'd0));
            // groups of three with at most MAX_TOK tokens gives 3/6/9/12
            w_final_ok = (w_pos_nxt == 2'd0);
         end
         MODE_POST_GRP: begin
            w_tok_ok   = (i_operator == (w_pos_base == 2'd2));
            w_final_ok = (w_pos_nxt == 2'd0);
         end
         MODE_PRE: begin
            w_tok_ok = (w_need_base != '0);
            if (w_tok_ok) begin
               w_need_nxt = i_operator ? w_need_base + LVL_W'(1)
                                       : w_need_base - LVL_W'(1);
            end
            w_final_ok = (w_need_nxt == '0);
         end
         default: begin
            if (i_operator) begin
               w_tok_ok = (w_depth_base >= LVL_W'(2));
               if (w_tok_ok) w_depth_nxt = w_depth_base - LVL_W'(1);
            end else begin
               w_depth_nxt = w_depth_base + LVL_W'(1);
            end
            w_final_ok = (w_depth_nxt == LVL_W'(1));
         end
      endcase

      w_ok_nxt   = w_ok_base & w_tok_ok;
      o_pass_c   = w_ok_nxt & w_final_ok;
      o_bad_op_c = w_bad_nxt;
   end

   // Counter state advances only on accepted tokens
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bad_op <= 1'b0;
         r_ok     <= 1'b1;
         r_need   <= LVL_W'(1);
         r_depth  <= '0;
         r_pos    <= '0;
      end else if (i_xfer) begin
         r_bad_op <= w_bad_nxt;
         r_ok     <= w_ok_nxt;
         r_need   <= w_need_nxt;
         r_depth  <= w_depth_nxt;
         r_pos    <= w_pos_nxt;
      end
   end

endmodule : pn_syntax_check

// File: rtl/pn_token_feeder.sv
// Front end of the Polish-notation evaluator: buffers one host expression,
// checks it, replays it as one contiguous pn_in_valid burst and reports
// done/err once the evaluator's result burst is over.
// Ports: host side cfg_mode/s_valid/s_ready/s_operator/s_value/s_last;
// evaluator side pn_mode/pn_operator/pn_in/pn_in_valid/pn_out_valid;
// status done/res_cnt, err/err_code, busy. All outputs registered.
module pn_token_feeder
   import pn_pkg::*;
#(
   parameter int unsigned MAX_TOK = PN_MAX_TOK,
   parameter int unsigned TIMEOUT = PN_TIMEOUT
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MODE_W-1:0] cfg_mode,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_operator,
   input  logic [VAL_W-1:0]  s_value,
   input  logic              s_last,
   output logic [MODE_W-1:0] pn_mode,
   output logic              pn_operator,
   output logic [VAL_W-1:0]  pn_in,
   output logic              pn_in_valid,
   input  logic              pn_out_valid,
   output logic              done,
   output logic [RES_W-1:0]  res_cnt,
   output logic              err,
   output logic [CODE_W-1:0] err_code,
   output logic              busy
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT);

   state_t            r_state, w_state_nxt;
   tok_t              r_buf [MAX_TOK];
   logic [MODE_W-1:0] r_mode, w_mode_nxt, w_mode;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, r_k, w_k_nxt, w_wr_idx;
   logic [RES_W-1:0]  r_acc, w_acc_nxt;
   logic              r_seen, w_seen_nxt;
   logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;

   logic              w_xfer, w_wr_en, w_eof, w_chk_xfer, w_pass_c, w_bad_op_c;
   tok_t              w_s_tok, w_first_tok, w_pn_tok_nxt;
   logic              w_pn_valid_nxt, w_done_nxt, w_err_nxt;
   logic [MODE_W-1:0] w_pn_mode_nxt;
   logic [RES_W-1:0]  w_res_nxt;
   logic [CODE_W-1:0] w_code_nxt;

   assign w_xfer      = s_valid & s_ready;
   assign w_s_tok     = '{op: s_operator, val: s_value};
   assign w_mode      = (r_state == ST_IDLE) ? cfg_mode : r_mode;
   // a one-token expression has not reached the buffer yet when SEND starts
   assign w_first_tok = (r_state == ST_IDLE) ? w_s_tok : r_buf[0];
   assign w_wr_idx    = (r_state == ST_IDLE) ? '0 : r_cnt;
   assign w_chk_xfer  = w_xfer & ((r_state == ST_IDLE) ||
                        ((r_state == ST_FILL) && (r_cnt != CNT_W'(MAX_TOK))));

   pn_syntax_check u_check (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_xfer     (w_chk_xfer),
      .i_first    (r_state == ST_IDLE),
      .i_mode     (w_mode),
      .i_operator (s_operator),
      .i_value    (s_value),
      .o_pass_c   (w_pass_c),
      .o_bad_op_c (w_bad_op_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state, datapath controls and next registered outputs
   always_comb begin
      w_state_nxt    = r_state;
      w_mode_nxt     = r_mode;
      w_cnt_nxt      = r_cnt;
      w_k_nxt        = r_k;
      w_acc_nxt      = r_acc;
      w_seen_nxt     = r_seen;
      w_tmo_nxt      = r_tmo;
      w_wr_en        = 1'b0;
      w_eof          = 1'b0;
      w_pn_valid_nxt = 1'b0;
      w_pn_tok_nxt   = '{op: pn_operator, val: pn_in};
      w_pn_mode_nxt  = pn_mode;
      w_done_nxt     = 1'b0;
      w_res_nxt      = '0;
      w_err_nxt      = 1'b0;
      w_code_nxt     = ERR_NONE;

      case (r_state)
         ST_IDLE: begin
            if (w_xfer) begin
               w_mode_nxt  = cfg_mode;
               w_wr_en     = 1'b1;
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = ST_FILL;
               w_eof       = s_last;
            end
         end
         ST_FILL: begin
            if (w_xfer) begin
               if (r_cnt == CNT_W'(MAX_TOK)) begin
                  // overflowing token is dropped
                  if (s_last) begin
                     w_err_nxt   = 1'b1;
                     w_code_nxt  = ERR_OVERFLOW;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_state_nxt = ST_DRAIN;
                  end
               end else begin
                  w_wr_en   = 1'b1;
                  w_cnt_nxt = r_cnt + CNT_W'(1);
                  w_eof     = s_last;
               end
            end
         end
         ST_DRAIN: begin
            if (w_xfer && s_last) begin
               w_err_nxt   = 1'b1;
               w_code_nxt  = ERR_OVERFLOW;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (r_k < r_cnt) begin
               w_pn_valid_nxt = 1'b1;
               w_pn_tok_nxt   = r_buf[r_k];
               w_k_nxt        = r_k + CNT_W'(1);
            end else begin
               w_state_nxt = ST_WAIT;
               w_acc_nxt   = '0;
               w_seen_nxt  = 1'b0;
               w_tmo_nxt   = '0;
            end
         end
         ST_WAIT: begin
            if (pn_out_valid) begin
               w_seen_nxt = 1'b1;
               if (r_acc != '1) w_acc_nxt = r_acc + RES_W'(1);
            end else if (r_seen) begin
               w_done_nxt  = 1'b1;
               w_res_nxt   = r_acc;
               w_state_nxt = ST_IDLE;
            end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
               w_err_nxt   = 1'b1;
               w_code_nxt  = ERR_TIMEOUT;
               w_state_nxt = ST_IDLE;
            end else begin
               w_tmo_nxt = r_tmo + TMO_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // End of fill: bad operator outranks a syntax failure
      if (w_eof) begin
         if (w_bad_op_c) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_BAD_OP;
            w_state_nxt = ST_IDLE;
         end else if (!w_pass_c) begin
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_SYNTAX;
            w_state_nxt = ST_IDLE;
         end else begin
            w_state_nxt    = ST_SEND;
            w_pn_valid_nxt = 1'b1;
            w_pn_tok_nxt   = w_first_tok;
            w_pn_mode_nxt  = w_mode;
            w_k_nxt        = CNT_W'(1);
         end
      end
   end

   // Datapath registers and buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MAX_TOK); i++) r_buf[i] <= '0;
         r_mode <= '0;
         r_cnt  <= '0;
         r_k    <= '0;
         r_acc  <= '0;
         r_seen <= 1'b0;
         r_tmo  <= '0;
      end else begin
         if (w_wr_en) r_buf[w_wr_idx] <= w_s_tok;
         r_mode <= w_mode_nxt;
         r_cnt  <= w_cnt_nxt;
         r_k    <= w_k_nxt;
         r_acc  <= w_acc_nxt;
         r_seen <= w_seen_nxt;
         r_tmo  <= w_tmo_nxt;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready     <= 1'b0;
         busy        <= 1'b0;
         pn_in_valid <= 1'b0;
         pn_operator <= 1'b0;
         pn_in       <= '0;
         pn_mode     <= '0;
         done        <= 1'b0;
         res_cnt     <= '0;
         err         <= 1'b0;
         err_code    <= '0;
      end else begin
         s_ready     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FILL) ||
                        (w_state_nxt == ST_DRAIN);
         busy        <= (w_state_nxt != ST_IDLE);
         pn_in_valid <= w_pn_valid_nxt;
         pn_operator <= w_pn_tok_nxt.op;
         pn_in       <= w_pn_tok_nxt.val;
         pn_mode     <= w_pn_mode_nxt;
         done        <= w_done_nxt;
         res_cnt     <= w_res_nxt;
         err         <= w_err_nxt;
         err_code    <= w_code_nxt;
      end
   end

endmodule : pn_token_feeder

// File: tb/tb_pn_token_feeder.sv
// Directed bench for pn_token_feeder with a small evaluator model that
// answers each input burst with a programmable number of out_valid cycles.
module tb_pn_token_feeder;
   import pn_pkg::*;

   localparam int TMO = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cfg_mode = '0;
   logic       s_valid = 1'b0, s_operator = 1'b0, s_last = 1'b0;
   logic [2:0] s_value = '0;
   logic       s_ready;
   logic [1:0] pn_mode;
   logic       pn_operator, pn_in_valid, pn_out_valid;
   logic [2:0] pn_in;
   logic       done, err, busy;
   logic [2:0] res_cnt, err_code;

   pn_token_feeder #(.MAX_TOK(12), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_operator(s_operator),
      .s_value(s_value), .s_last(s_last),
      .pn_mode(pn_mode), .pn_operator(pn_operator), .pn_in(pn_in),
      .pn_in_valid(pn_in_valid), .pn_out_valid(pn_out_valid),
      .done(done), .res_cnt(res_cnt), .err(err), .err_code(err_code),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor
   int pv_cyc[$], pv_tok[$], pv_mode[$], dn_cyc[$], dn_res[$], er_cyc[$], er_code[$];
   always @(negedge clk) begin
      if (pn_in_valid) begin
         pv_cyc.push_back(cyc);
         pv_tok.push_back(int'({pn_operator, pn_in}));
         pv_mode.push_back(int'(pn_mode));
      end
      if (done) begin
         dn_cyc.push_back(cyc);
         dn_res.push_back(int'(res_cnt));
      end
      if (err) begin
         er_cyc.push_back(cyc);
         er_code.push_back(int'(err_code));
      end
   end

   task automatic clear_mon();
      pv_cyc.delete(); pv_tok.delete(); pv_mode.delete();
      dn_cyc.delete(); dn_res.delete(); er_cyc.delete(); er_code.delete();
   endtask

   // Evaluator model: eval_n out_valid cycles, starting one cycle after the burst
   int eval_n = 0;
   initial begin : eval_model
      logic prev;
      prev = 1'b0;
      pn_out_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (prev && !pn_in_valid && eval_n > 0) begin
            @(posedge clk); #1 pn_out_valid = 1'b1;
            repeat (eval_n) @(posedge clk);
            #1 pn_out_valid = 1'b0;
            prev = 1'b0;
         end else begin
            prev = pn_in_valid;
         end
      end
   end

   logic [3:0] vec [16];
   int nv = 0;
   int t_last = 0;

   task automatic push(input logic op, input logic [2:0] v);
      vec[nv] = {op, v};
      nv++;
   endtask

   // Drive the queued tokens; t_last is the cycle number of the s_last handshake
   task automatic send_expr(input logic [1:0] mode);
      int  w;
      logic hs;
      clear_mon();
      for (int i = 0; i < nv; i++) begin
         cfg_mode   = mode;
         s_valid    = 1'b1;
         s_operator = vec[i][3];
         s_value    = vec[i][2:0];
         s_last     = (i == nv - 1);
         hs = 1'b0;
         w  = 0;
         while (!hs && w < 50) begin
            hs = s_ready;
            @(posedge clk); #1;
            w++;
         end
         if (!hs) chk("handshake_timeout", 0, 1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      t_last  = cyc;
      nv = 0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      do begin
         @(posedge clk); #1;
         w++;
      end while (busy && w < 400);
      if (busy) chk("idle_timeout", 1, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Expected: burst of exp_tok starting the cycle after t_last, then done with res
   task automatic chk_done(input string tag, input int mode, input int exp_tok[$],
                           input int n_out, input int res);
      int n;
      n = exp_tok.size();
      chk({tag, "_burst_len"}, pv_tok.size(), n);
      for (int i = 0; i < n && i < pv_tok.size(); i++) begin
         chk({tag, "_tok"}, pv_tok[i], exp_tok[i]);
         chk({tag, "_tok_cyc"}, pv_cyc[i], t_last + i);
         chk({tag, "_mode"}, pv_mode[i], mode);
      end
      chk({tag, "_done_cnt"}, dn_cyc.size(), 1);
      chk({tag, "_err_cnt"}, er_cyc.size(), 0);
      if (dn_cyc.size() > 0) begin
         chk({tag, "_res_cnt"}, dn_res[0], res);
         chk({tag, "_done_cyc"}, dn_cyc[0], t_last + n - 1 + n_out + 3);
      end
   endtask

   task automatic chk_err(input string tag, input int code, input int exp_cyc,
                          input int exp_burst);
      chk({tag, "_err_cnt"}, er_cyc.size(), 1);
      chk({tag, "_done_cnt"}, dn_cyc.size(), 0);
      chk({tag, "_burst_len"}, pv_tok.size(), exp_burst);
      if (er_cyc.size() > 0) begin
         chk({tag, "_code"}, er_code[0], code);
         chk({tag, "_err_cyc"}, er_cyc[0], exp_cyc);
      end
   endtask

   function automatic int out_vec();
      return int'({s_ready, busy, pn_in_valid, done, err, pn_mode, pn_operator,
                   pn_in, res_cnt, err_code});
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : stim
      // reset values
      #23;
      chk("reset_outputs", out_vec(), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_s_ready", int'(s_ready), 1);
      chk("idle_busy", int'(busy), 0);

      // postfix 3 4 +
      eval_n = 1;
      push(0, 3); push(0, 4); push(1, 0);
      send_expr(MODE_POST);
      chk("post_ready_in_send", int'(s_ready), 0);
      chk("post_busy_in_send", int'(busy), 1);
      wait_idle();
      chk_done("post", 3, '{3, 4, 8}, 1, 1);

      // grouped prefix, two groups
      eval_n = 2;
      push(1, 2); push(0, 5); push(0, 1); push(1, 0); push(0, 2); push(0, 3);
      send_expr(MODE_PRE_GRP);
      wait_idle();
      chk_done("pregrp", 0, '{10, 5, 1, 8, 2, 3}, 2, 2);

      // grouped postfix
      eval_n = 3;
      push(0, 1); push(0, 2); push(1, 2);
      send_expr(MODE_POST_GRP);
      wait_idle();
      chk_done("postgrp", 1, '{1, 2, 10}, 3, 3);

      // prefix, result counter saturates at 7
      eval_n = 9;
      push(1, 2); push(0, 1); push(0, 2);
      send_expr(MODE_PRE);
      wait_idle();
      chk_done("pre_sat", 2, '{10, 1, 2}, 9, 7);

      // prefix missing an operand
      eval_n = 1;
      push(1, 0); push(0, 3);
      send_expr(MODE_PRE);
      wait_idle();
      chk_err("pre_short", 2, t_last, 0);

      // single bad operator: bad_op outranks the syntax failure
      push(1, 5);
      send_expr(MODE_POST);
      wait_idle();
      chk_err("bad_op", 1, t_last, 0);

      // grouped prefix with a token count that is not a multiple of 3
      push(1, 0); push(0, 1); push(0, 2); push(1, 0);
      send_expr(MODE_PRE_GRP);
      wait_idle();
      chk_err("grp_len", 2, t_last, 0);

      // 13 operands then s_last on the 14th
      for (int i = 0; i < 14; i++) push(0, 3'(i));
      send_expr(MODE_POST);
      chk("ovf_drain_err", int'(err), 1);
      chk("ovf_drain_code", int'(err_code), 3);
      chk("ovf_drain_busy", int'(busy), 0);
      wait_idle();
      chk_err("ovf_drain", 3, t_last, 0);

      // s_last on the 13th token
      for (int i = 0; i < 13; i++) push(0, 3'(i));
      send_expr(MODE_POST);
      wait_idle();
      chk_err("ovf_13", 3, t_last, 0);

      // no evaluator response: timeout after a one-token burst
      eval_n = 0;
      push(0, 1);
      send_expr(MODE_POST);
      wait_idle();
      chk_err("timeout", 4, t_last + 1 + TMO, 1);

      // reset during the second SEND cycle
      eval_n = 0;
      push(0, 3); push(0, 4); push(1, 0);
      send_expr(MODE_POST);
      @(posedge clk); #2;
      chk("rst_pre_valid", int'(pn_in_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_send", out_vec(), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      eval_n = 1;
      push(0, 3); push(0, 4); push(1, 0);
      send_expr(MODE_POST);
      wait_idle();
      chk_done("post_rst", 3, '{3, 4, 8}, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_pn_token_feeder
